// File: rtl/controle_pkg.sv
// ============================================================================
//  Module : controle_pkg
//  Brief  : Opcodes, ALU encodings, FSM states and instruction classes for
//           the multicycle control unit.
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package controle_pkg;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_MULT  = 6'd4;
  localparam logic [5:0] OP_MOVE  = 6'd5;
  localparam logic [5:0] OP_BEQ   = 6'd6;
  localparam logic [5:0] OP_BNEQ  = 6'd7;
  localparam logic [5:0] OP_SGT   = 6'd8;
  localparam logic [5:0] OP_SLT   = 6'd9;
  localparam logic [5:0] OP_BEQZ  = 6'd10;
  localparam logic [5:0] OP_BEQO  = 6'd11;
  localparam logic [5:0] OP_LOAD  = 6'd12;
  localparam logic [5:0] OP_STORE = 6'd13;
  localparam logic [5:0] OP_JUMP  = 6'd14;
  localparam logic [5:0] OP_DIV   = 6'd15;
  localparam logic [5:0] OP_HALT  = 6'd63;

  localparam logic [2:0] ULA_SEL_ADD   = 3'b000;
  localparam logic [2:0] ULA_SEL_SUB   = 3'b001;
  localparam logic [2:0] ULA_SEL_AND   = 3'b010;
  localparam logic [2:0] ULA_SEL_OR    = 3'b011;
  localparam logic [2:0] ULA_SEL_MULT  = 3'b100;
  localparam logic [2:0] ULA_SEL_DIV   = 3'b110;
  localparam logic [2:0] ULA_SEL_PASSA = 3'b111;

  localparam logic [2:0] ULA_COMP_NENHUM = 3'b000;
  localparam logic [2:0] ULA_COMP_BEQ    = 3'b001;
  localparam logic [2:0] ULA_COMP_BNEQ   = 3'b010;
  localparam logic [2:0] ULA_COMP_SGT    = 3'b011;
  localparam logic [2:0] ULA_COMP_SLT    = 3'b100;
  localparam logic [2:0] ULA_COMP_BEQZ   = 3'b101;
  localparam logic [2:0] ULA_COMP_BEQO   = 3'b111;

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    PARADO     = 3'd5,
    ERRO       = 3'd6
  } estado_t;

  typedef enum logic [2:0] {
    CLS_ALU      = 3'd0,
    CLS_DESVIO   = 3'd1,
    CLS_SALTO    = 3'd2,
    CLS_CARGA    = 3'd3,
    CLS_ARMAZENA = 3'd4,
    CLS_PARADA   = 3'd5,
    CLS_ILEGAL   = 3'd6
  } classe_t;

endpackage

`default_nettype wire

// File: rtl/decodificador_instrucao.sv
// ============================================================================
//  Module : decodificador_instrucao
//  Brief  : Combinational opcode -> {class, ALU op, ALU compare} decoder.
//           Macro UNIDADE_CONTROLE_DIV_EN makes opcode 15 (DIV) legal.
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decodificador_instrucao
  import controle_pkg::*;
#(
  parameter int LARGURA_OPCODE = 6
) (
  input  logic [LARGURA_OPCODE-1:0] opcode,
  output classe_t                   classe,
  output logic [2:0]                ula_sel,
  output logic [2:0]                ula_comp
);

  always_comb begin
    classe   = CLS_ILEGAL;
    ula_sel  = ULA_SEL_ADD;
    ula_comp = ULA_COMP_NENHUM;
    case (opcode)
      LARGURA_OPCODE'(OP_ADD):   classe = CLS_ALU;
      LARGURA_OPCODE'(OP_SUB):   begin classe = CLS_ALU; ula_sel = ULA_SEL_SUB;   end
      LARGURA_OPCODE'(OP_AND):   begin classe = CLS_ALU; ula_sel = ULA_SEL_AND;   end
      LARGURA_OPCODE'(OP_OR):    begin classe = CLS_ALU; ula_sel = ULA_SEL_OR;    end
      LARGURA_OPCODE'(OP_MULT):  begin classe = CLS_ALU; ula_sel = ULA_SEL_MULT;  end
      LARGURA_OPCODE'(OP_MOVE):  begin classe = CLS_ALU; ula_sel = ULA_SEL_PASSA; end
      LARGURA_OPCODE'(OP_SGT):   begin classe = CLS_ALU; ula_sel = ULA_SEL_SUB; ula_comp = ULA_COMP_SGT; end
      LARGURA_OPCODE'(OP_SLT):   begin classe = CLS_ALU; ula_sel = ULA_SEL_SUB; ula_comp = ULA_COMP_SLT; end
      LARGURA_OPCODE'(OP_BEQ):   begin classe = CLS_DESVIO; ula_sel = ULA_SEL_SUB; ula_comp = ULA_COMP_BEQ;  end
      LARGURA_OPCODE'(OP_BNEQ):  begin classe = CLS_DESVIO; ula_sel = ULA_SEL_SUB; ula_comp = ULA_COMP_BNEQ; end
      LARGURA_OPCODE'(OP_BEQZ):  begin classe = CLS_DESVIO; ula_sel = ULA_SEL_SUB; ula_comp = ULA_COMP_BEQZ; end
      LARGURA_OPCODE'(OP_BEQO):  begin classe = CLS_DESVIO; ula_sel = ULA_SEL_SUB; ula_comp = ULA_COMP_BEQO; end
      LARGURA_OPCODE'(OP_LOAD):  classe = CLS_CARGA;
      LARGURA_OPCODE'(OP_STORE): classe = CLS_ARMAZENA;
      LARGURA_OPCODE'(OP_JUMP):  begin classe = CLS_SALTO; ula_sel = ULA_SEL_PASSA; end
`ifdef UNIDADE_CONTROLE_DIV_EN
      LARGURA_OPCODE'(OP_DIV):   begin classe = CLS_ALU; ula_sel = ULA_SEL_DIV; end
`endif
      LARGURA_OPCODE'(OP_HALT):  classe = CLS_PARADA;
      default:                   classe = CLS_ILEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/unidade_controle.sv
// ============================================================================
//  Module : unidade_controle
//  Brief  : Multicycle control FSM: fetch handshake, decode, ALU sequencing,
//           memory access, writeback. Optional macro UNIDADE_CONTROLE_DIV_EN.
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unidade_controle
  import controle_pkg::*;
#(
  parameter int LARGURA_OPCODE = 6,
  parameter int PC_PASSO       = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instrucao,
  input  logic        mem_pronto,
  input  logic        zero,
  output logic        mem_le,
  output logic        mem_escreve,
  output logic        mem_end_fonte,
  output logic        ir_escreve,
  output logic        pc_incrementa,
  output logic        pc_carrega,
  output logic        reg_escreve,
  output logic        reg_dado_fonte,
  output logic [2:0]  ula_sel,
  output logic [2:0]  ula_comp,
  output logic        ula_fonte_b,
  output logic        parado,
  output logic        instr_ilegal
);

  if (LARGURA_OPCODE != 6 || PC_PASSO <= 0) begin : g_parametros_invalidos
    $error("unidade_controle: unsupported LARGURA_OPCODE/PC_PASSO");
  end

  estado_t                   r_estado;
  estado_t                   w_proximo;
  logic [LARGURA_OPCODE-1:0] r_opcode;
  classe_t                   w_classe;
  logic [2:0]                w_sel;
  logic [2:0]                w_comp;
  logic                      w_mem_op;
  logic                      w_unused_campos;

  assign w_unused_campos = ^instrucao[31-LARGURA_OPCODE:0];
  assign w_mem_op        = (w_classe == CLS_CARGA) || (w_classe == CLS_ARMAZENA);

  decodificador_instrucao #(
    .LARGURA_OPCODE (LARGURA_OPCODE)
  ) u_decodificador (
    .opcode   (r_opcode),
    .classe   (w_classe),
    .ula_sel  (w_sel),
    .ula_comp (w_comp)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= BUSCA;
      r_opcode <= '0;
    end else begin
      r_estado <= w_proximo;
      if (r_estado == BUSCA && mem_pronto)
        r_opcode <= instrucao[31 -: LARGURA_OPCODE];
    end
  end

  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      BUSCA:      if (mem_pronto) w_proximo = DECODIFICA;
      DECODIFICA: begin
        case (w_classe)
          CLS_ILEGAL: w_proximo = ERRO;
          CLS_PARADA: w_proximo = PARADO;
          default:    w_proximo = EXECUTA;
        endcase
      end
      EXECUTA: begin
        case (w_classe)
          CLS_ALU:                w_proximo = ESCRITA;
          CLS_CARGA, CLS_ARMAZENA: w_proximo = MEMORIA;
          default:                w_proximo = BUSCA;
        endcase
      end
      MEMORIA: if (mem_pronto) w_proximo = (w_classe == CLS_CARGA) ? ESCRITA : BUSCA;
      ESCRITA: w_proximo = BUSCA;
      PARADO:  w_proximo = PARADO;
      ERRO:    w_proximo = ERRO;
      default: w_proximo = BUSCA;
    endcase
  end

  // Gated by reset_n so a mid-handshake reset drops every strobe at once.
  always_comb begin
    mem_le         = 1'b0;
    mem_escreve    = 1'b0;
    mem_end_fonte  = 1'b0;
    ir_escreve     = 1'b0;
    pc_incrementa  = 1'b0;
    pc_carrega     = 1'b0;
    reg_escreve    = 1'b0;
    reg_dado_fonte = 1'b0;
    ula_sel        = ULA_SEL_ADD;
    ula_comp       = ULA_COMP_NENHUM;
    ula_fonte_b    = 1'b0;
    parado         = 1'b0;
    instr_ilegal   = 1'b0;
    if (reset_n) begin
      case (r_estado)
        BUSCA: begin
          mem_le        = 1'b1;
          ir_escreve    = mem_pronto;
          pc_incrementa = mem_pronto;
        end
        EXECUTA: begin
          ula_sel     = w_sel;
          ula_comp    = w_comp;
          ula_fonte_b = w_mem_op;
          if (w_classe == CLS_DESVIO) pc_carrega = zero;
          if (w_classe == CLS_SALTO)  pc_carrega = 1'b1;
        end
        MEMORIA: begin
          ula_sel       = w_sel;
          ula_comp      = w_comp;
          ula_fonte_b   = 1'b1;
          mem_end_fonte = 1'b1;
          mem_le        = (w_classe == CLS_CARGA);
          mem_escreve   = (w_classe == CLS_ARMAZENA);
        end
        ESCRITA: begin
          ula_sel        = w_sel;
          ula_comp       = w_comp;
          ula_fonte_b    = (w_classe == CLS_CARGA);
          reg_escreve    = 1'b1;
          reg_dado_fonte = (w_classe == CLS_CARGA);
        end
        PARADO:  parado       = 1'b1;
        ERRO:    instr_ilegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unidade_controle.sv
// ============================================================================
//  Module : tb_unidade_controle
//  Brief  : Randomized self-checking bench for unidade_controle against a
//           per-instruction cycle model.
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unidade_controle;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instrucao;
  logic        mem_pronto;
  logic        zero;
  logic        mem_le, mem_escreve, mem_end_fonte, ir_escreve, pc_incrementa;
  logic        pc_carrega, reg_escreve, reg_dado_fonte, ula_fonte_b, parado, instr_ilegal;
  logic [2:0]  ula_sel, ula_comp;

  int n_cmp = 0;
  int n_bad = 0;
  int ciclo = 0;

  typedef struct packed {
    logic        pronto;
    logic        z;
    logic [31:0] instr;
    logic [16:0] esp;
  } passo_t;

  passo_t fila[$];
  logic [16:0] saida;

  assign saida = {mem_le, mem_escreve, mem_end_fonte, ir_escreve, pc_incrementa,
                  pc_carrega, reg_escreve, reg_dado_fonte, ula_sel, ula_comp,
                  ula_fonte_b, parado, instr_ilegal};

  always #5 clock = ~clock;

  unidade_controle #(.LARGURA_OPCODE(6), .PC_PASSO(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .instrucao      (instrucao),
    .mem_pronto     (mem_pronto),
    .zero           (zero),
    .mem_le         (mem_le),
    .mem_escreve    (mem_escreve),
    .mem_end_fonte  (mem_end_fonte),
    .ir_escreve     (ir_escreve),
    .pc_incrementa  (pc_incrementa),
    .pc_carrega     (pc_carrega),
    .reg_escreve    (reg_escreve),
    .reg_dado_fonte (reg_dado_fonte),
    .ula_sel        (ula_sel),
    .ula_comp       (ula_comp),
    .ula_fonte_b    (ula_fonte_b),
    .parado         (parado),
    .instr_ilegal   (instr_ilegal)
  );

  function automatic logic [16:0] vetor(input logic le, input logic esc, input logic endf,
                                        input logic ir, input logic pci, input logic pcc,
                                        input logic rw, input logic rdf, input logic [2:0] sel,
                                        input logic [2:0] comp, input logic fb,
                                        input logic par, input logic il);
    return {le, esc, endf, ir, pci, pcc, rw, rdf, sel, comp, fb, par, il};
  endfunction

  task automatic empurra(input logic pronto, input logic z, input logic [31:0] instr,
                         input logic [16:0] esp);
    passo_t p;
    p.pronto = pronto; p.z = z; p.instr = instr; p.esp = esp;
    fila.push_back(p);
  endtask

  // Expected cycle-by-cycle trace of one instruction; wf/wm are wait cycles.
  task automatic monta(input logic [5:0] op, input int wf, input int wm, input logic z_exec);
    int         cls;  // 0 alu 1 branch 2 jump 3 load 4 store 5 halt 6 illegal
    logic [2:0] sel, comp;
    logic       ld, st, pcc;
    cls = 6; sel = 3'b000; comp = 3'b000;
    case (op)
      6'd0:  cls = 0;
      6'd1:  begin cls = 0; sel = 3'b001; end
      6'd2:  begin cls = 0; sel = 3'b010; end
      6'd3:  begin cls = 0; sel = 3'b011; end
      6'd4:  begin cls = 0; sel = 3'b100; end
      6'd5:  begin cls = 0; sel = 3'b111; end
      6'd8:  begin cls = 0; sel = 3'b001; comp = 3'b011; end
      6'd9:  begin cls = 0; sel = 3'b001; comp = 3'b100; end
      6'd6:  begin cls = 1; sel = 3'b001; comp = 3'b001; end
      6'd7:  begin cls = 1; sel = 3'b001; comp = 3'b010; end
      6'd10: begin cls = 1; sel = 3'b001; comp = 3'b101; end
      6'd11: begin cls = 1; sel = 3'b001; comp = 3'b111; end
      6'd12: cls = 3;
      6'd13: cls = 4;
      6'd14: begin cls = 2; sel = 3'b111; end
`ifdef UNIDADE_CONTROLE_DIV_EN
      6'd15: begin cls = 0; sel = 3'b110; end
`endif
      6'd63: cls = 5;
      default: cls = 6;
    endcase
    ld = (cls == 3);
    st = (cls == 4);
    for (int i = 0; i < wf; i++)
      empurra(1'b0, 1'($urandom), $urandom, vetor(1,0,0,0,0,0,0,0,3'd0,3'd0,0,0,0));
    empurra(1'b1, 1'($urandom), {op, 26'($urandom)}, vetor(1,0,0,1,1,0,0,0,3'd0,3'd0,0,0,0));
    empurra(1'($urandom), 1'($urandom), $urandom, '0);
    if (cls == 5) begin
      for (int i = 0; i < 20; i++)
        empurra(1'($urandom), 1'($urandom), $urandom, vetor(0,0,0,0,0,0,0,0,3'd0,3'd0,0,1,0));
      return;
    end
    if (cls == 6) begin
      for (int i = 0; i < 20; i++)
        empurra(1'($urandom), 1'($urandom), $urandom, vetor(0,0,0,0,0,0,0,0,3'd0,3'd0,0,0,1));
      return;
    end
    pcc = (cls == 1) ? z_exec : (cls == 2);
    empurra(1'($urandom), z_exec, $urandom, vetor(0,0,0,0,0,pcc,0,0,sel,comp,ld|st,0,0));
    if (ld || st) begin
      for (int i = 0; i < wm; i++)
        empurra(1'b0, 1'($urandom), $urandom, vetor(ld,st,1,0,0,0,0,0,sel,comp,1,0,0));
      empurra(1'b1, 1'($urandom), $urandom, vetor(ld,st,1,0,0,0,0,0,sel,comp,1,0,0));
    end
    if (cls == 0 || ld)
      empurra(1'($urandom), 1'($urandom), $urandom, vetor(0,0,0,0,0,0,1,ld,sel,comp,ld,0,0));
  endtask

  task automatic aplica_reset();
    reset_n = 1'b0; mem_pronto = 1'b0; zero = 1'b0; instrucao = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    aplica_reset();
    @(negedge clock);
    n_cmp++;
    if (saida !== vetor(1,0,0,0,0,0,0,0,3'd0,3'd0,0,0,0)) begin
      n_bad++; $display("FAIL reset_busca got=%h exp=%h", saida, vetor(1,0,0,0,0,0,0,0,3'd0,3'd0,0,0,0));
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (saida !== 17'd0) begin
      n_bad++; $display("FAIL reset_imediato got=%h exp=%h", saida, 17'd0);
    end
    mem_pronto = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if (saida !== 17'd0) begin
      n_bad++; $display("FAIL reset_mantido got=%h exp=%h", saida, 17'd0);
    end
    reset_n = 1'b1; mem_pronto = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (saida !== vetor(1,0,0,0,0,0,0,0,3'd0,3'd0,0,0,0)) begin
      n_bad++; $display("FAIL reset_liberado got=%h exp=%h", saida, vetor(1,0,0,0,0,0,0,0,3'd0,3'd0,0,0,0));
    end
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    passo_t p;
    monta(6'd0, 0, 0, 1'($urandom));
    monta(6'd6, 0, 0, 1'b1);
    monta(6'd6, 0, 0, 1'b0);
    monta(6'd12, 0, 3, 1'($urandom));
    monta(6'd13, 1, 0, 1'($urandom));
    monta(6'd14, 0, 0, 1'($urandom));
    monta(6'd8, 2, 0, 1'($urandom));
    while (fila.size() > 0) begin
      p = fila.pop_front();
      mem_pronto = p.pronto; zero = p.z; instrucao = p.instr;
      @(negedge clock);
      n_cmp++;
      if (saida !== p.esp) begin
        n_bad++; $display("FAIL directed ciclo=%0d got=%h exp=%h", ciclo, saida, p.esp);
      end
      ciclo++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_stream();
    passo_t p;
    for (int k = 0; k < 150; k++)
      monta(6'($urandom_range(0, 14)), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    while (fila.size() > 0) begin
      p = fila.pop_front();
      mem_pronto = p.pronto; zero = p.z; instrucao = p.instr;
      @(negedge clock);
      n_cmp++;
      if (saida !== p.esp) begin
        n_bad++; $display("FAIL stream ciclo=%0d got=%h exp=%h", ciclo, saida, p.esp);
      end
      ciclo++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_ilegal();
    passo_t p;
    for (int r = 0; r < 2; r++) begin
      aplica_reset();
      monta((r == 0) ? 6'd15 : 6'($urandom_range(16, 62)), $urandom_range(0, 2), 0, 1'($urandom));
      while (fila.size() > 0) begin
        p = fila.pop_front();
        mem_pronto = p.pronto; zero = p.z; instrucao = p.instr;
        @(negedge clock);
        n_cmp++;
        if (saida !== p.esp) begin
          n_bad++; $display("FAIL ilegal ciclo=%0d got=%h exp=%h", ciclo, saida, p.esp);
        end
        ciclo++;
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_halt();
    passo_t p;
    aplica_reset();
    monta(6'd3, 0, 0, 1'($urandom));
    monta(6'd63, 1, 0, 1'($urandom));
    while (fila.size() > 0) begin
      p = fila.pop_front();
      mem_pronto = p.pronto; zero = p.z; instrucao = p.instr;
      @(negedge clock);
      n_cmp++;
      if (saida !== p.esp) begin
        n_bad++; $display("FAIL halt ciclo=%0d got=%h exp=%h", ciclo, saida, p.esp);
      end
      ciclo++;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; mem_pronto = 1'b0; zero = 1'b0; instrucao = '0;
    test_reset();
    test_directed();
    test_stream();
    test_ilegal();
    test_halt();
    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
